// File: rtl/i2c_encoder.sv
// i2c_encoder: single-byte I2C master transmitter.
// Drives START, eight data bits MSB-first, one ACK clock with SDA released,
// then STOP, and reports the ACK level sampled from the bus.
// Every bus phase lasts one quarter of an SCL period (CLK_DIV system clocks).
module i2c_encoder #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic       sda_in,
    output logic       scl_out,
    output logic       sda_out,
    output logic       busy,
    output logic       done,
    output logic       ack
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_ACK,
        S_STOP
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state_q;
    logic [7:0] div_q;
    logic [1:0] quarter_q;
    logic [2:0] bit_idx_q;
    logic [7:0] data_q;
    logic       scl_q;
    logic       sda_q;
    logic       busy_q;
    logic       done_q;
    logic       ack_q;
    logic       tick;

    // Last system clock of the current quarter.
    assign tick = (div_q == DIV_LAST);

    // Transfer sequencer: advances one phase per quarter and registers the bus levels for the next phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            quarter_q <= '0;
            bit_idx_q <= '0;
            // NOTE: the byte register is reset like every other register so a
            // reset mid-transfer leaves no stale data behind.
            data_q    <= '0;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            // NOTE: all state uses <= so every decision below sees pre-edge values,
            // e.g. data_q[bit_idx_q - 1] reads the old index, not the decremented one.
            done_q <= 1'b0;
            if (state_q == S_IDLE) begin
                div_q     <= '0;
                quarter_q <= '0;
                if (start) begin
                    data_q    <= data_in;
                    bit_idx_q <= 3'd7;
                    state_q   <= S_START;
                    busy_q    <= 1'b1;
                    scl_q     <= 1'b1;
                    sda_q     <= 1'b0;
                end
            end else if (!tick) begin
                div_q <= div_q + 8'd1;
            end else begin
                div_q     <= '0;
                quarter_q <= quarter_q + 2'd1;
                case (state_q)
                    S_START: begin
                        if (quarter_q == 2'd0) begin
                            scl_q <= 1'b0;
                        end else begin
                            state_q   <= S_DATA;
                            quarter_q <= '0;
                            scl_q     <= 1'b0;
                            sda_q     <= data_q[bit_idx_q];
                        end
                    end
                    S_DATA: begin
                        case (quarter_q)
                            2'd1: scl_q <= 1'b1;
                            2'd3: begin
                                scl_q <= 1'b0;
                                if (bit_idx_q == 3'd0) begin
                                    state_q <= S_ACK;
                                    sda_q   <= 1'b1;
                                end else begin
                                    bit_idx_q <= bit_idx_q - 3'd1;
                                    sda_q     <= data_q[bit_idx_q - 3'd1];
                                end
                            end
                            default: ;
                        endcase
                    end
                    S_ACK: begin
                        case (quarter_q)
                            2'd1: scl_q <= 1'b1;
                            // Target drives SDA low to acknowledge; sample at the end of the high quarter.
                            2'd2: ack_q <= !sda_in;
                            2'd3: begin
                                state_q <= S_STOP;
                                scl_q   <= 1'b0;
                                sda_q   <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                    S_STOP: begin
                        case (quarter_q)
                            2'd0: scl_q <= 1'b1;
                            2'd1: sda_q <= 1'b1;
                            default: begin
                                state_q   <= S_IDLE;
                                quarter_q <= '0;
                                busy_q    <= 1'b0;
                                done_q    <= 1'b1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign scl_out = scl_q;
    assign sda_out = sda_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ack     = ack_q;

endmodule

// File: tb/tb_i2c_encoder.sv
// Testbench for i2c_encoder: two instances (CLK_DIV=4 and CLK_DIV=1) share
// one bus monitor through a selector. The stimulus pushes the expected byte
// and ACK into a scoreboard queue; the monitor decodes the bus and pops an
// entry on every done pulse.
module tb_i2c_encoder;

    typedef struct {
        logic [7:0] data;
        logic       ack;
    } exp_t;

    exp_t sb_q[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_r = 1'b0;
    logic [7:0] data_r = 8'h00;
    logic       sel = 1'b0;       // 0: CLK_DIV=4 instance, 1: CLK_DIV=1 instance
    logic       pull_en = 1'b0;   // target acknowledges
    logic       sda_hi = 1'b0;    // force sda_in high throughout

    int n_checks = 0;
    int n_err = 0;

    logic scl4, sda4, busy4, done4, ack4, sda_in4, start4;
    logic scl1, sda1, busy1, done1, ack1, sda_in1, start1;

    logic mon_scl, mon_sda, mon_busy, mon_done, mon_ack;
    logic mon_active = 1'b0;
    logic mon_stop = 1'b0;
    logic [7:0] mon_byte = 8'h00;
    int   mon_bits = 0;
    logic prev_scl = 1'b1;
    logic prev_sda = 1'b1;
    logic pull_now;

    always #5 clk = ~clk;

    assign start4   = start_r & ~sel;
    assign start1   = start_r & sel;
    assign pull_now = pull_en && mon_active && (mon_bits >= 8);
    assign sda_in4  = sda_hi ? 1'b1 : (sda4 & ~(pull_now & ~sel));
    assign sda_in1  = sda_hi ? 1'b1 : (sda1 & ~(pull_now & sel));

    assign mon_scl  = sel ? scl1  : scl4;
    assign mon_sda  = sel ? sda1  : sda4;
    assign mon_busy = sel ? busy1 : busy4;
    assign mon_done = sel ? done1 : done4;
    assign mon_ack  = sel ? ack1  : ack4;

    i2c_encoder #(.CLK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .data_in(data_r), .sda_in(sda_in4),
        .scl_out(scl4), .sda_out(sda4), .busy(busy4), .done(done4), .ack(ack4)
    );

    i2c_encoder #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .data_in(data_r), .sda_in(sda_in1),
        .scl_out(scl1), .sda_out(sda1), .busy(busy1), .done(done1), .ack(ack1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bus monitor: decodes START/bits/STOP from the selected instance, scores on done.
    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
            mon_bits   = 0;
            mon_byte   = 8'h00;
            mon_stop   = 1'b0;
        end else begin
            if (prev_scl && mon_scl && prev_sda && !mon_sda) begin
                check("start_only_when_idle", {31'd0, mon_active}, 32'd0);
                mon_active = 1'b1;
                mon_bits   = 0;
                mon_byte   = 8'h00;
                mon_stop   = 1'b0;
            end else if (prev_scl && mon_scl && !prev_sda && mon_sda) begin
                check("stop_after_ack_clock", mon_bits, 9);
                mon_active = 1'b0;
                mon_stop   = 1'b1;
            end else if (!prev_scl && mon_scl && mon_active) begin
                if (mon_bits < 8) mon_byte = {mon_byte[6:0], mon_sda};
                if (mon_bits < 9) mon_bits++;
            end
            if (mon_done) begin
                check("done_has_expected_entry", {31'd0, sb_q.size() > 0}, 32'd1);
                if (sb_q.size() > 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("decoded_byte", mon_byte, e.data);
                    check("ack_out", mon_ack, e.ack);
                    check("stop_seen", mon_stop, 1);
                    check("bus_idle_at_done", {mon_scl, mon_sda, mon_busy}, 3'b110);
                end
                mon_stop = 1'b0;
                mon_bits = 0;
            end
        end
        prev_scl = mon_scl;
        prev_sda = mon_sda;
    end

    // One transfer on the selected instance, with timing checks from the start side.
    task automatic run_xfer(input logic [7:0] d, input logic pull, input int div, input int repulse_at);
        int cyc;
        int busy_cnt;
        exp_t e;
        pull_en = pull;
        data_r  = d;
        start_r = 1'b1;
        e.data = d;
        e.ack  = pull;
        sb_q.push_back(e);
        @(posedge clk); #1;
        start_r = 1'b0;
        cyc = 1;
        busy_cnt = 0;
        check("start_q0_bus", {mon_scl, mon_sda, mon_busy}, 3'b101);
        if (mon_busy) busy_cnt++;
        while (!mon_done && cyc < 41 * div + 20) begin
            @(posedge clk); #1;
            cyc++;
            if (mon_busy) busy_cnt++;
            if (repulse_at != 0 && cyc == repulse_at) begin
                start_r = 1'b1;
                data_r  = 8'hFF;
            end else if (repulse_at != 0 && cyc == repulse_at + 1) begin
                start_r = 1'b0;
                data_r  = d;
            end
        end
        check("done_cycle", cyc, 41 * div + 1);
        check("busy_cycles", busy_cnt, 41 * div);
        @(posedge clk); #1;
        check("done_single_cycle", {31'd0, mon_done}, 32'd0);
    endtask

    initial begin
        int dones;
        int cyc;
        int last;
        logic after_done;

        // Reset values on both instances.
        repeat (2) @(posedge clk);
        #1;
        check("rst4_bus", {scl4, sda4}, 2'b11);
        check("rst4_busy_done", {busy4, done4}, 2'b00);
        check("rst4_ack", {31'd0, ack4}, 32'd0);
        check("rst1_bus", {scl1, sda1}, 2'b11);
        check("rst1_busy_done_ack", {busy1, done1, ack1}, 3'b000);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 0xA5 with the target acknowledging.
        run_xfer(8'hA5, 1'b1, 4, 0);
        repeat (3) @(posedge clk);
        #1;

        // 0x3C with SDA held high: no acknowledge.
        sda_hi = 1'b1;
        run_xfer(8'h3C, 1'b0, 4, 0);
        sda_hi = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Start re-pulsed with 0xFF mid-transfer must be ignored.
        run_xfer(8'h96, 1'b1, 4, 60);
        dones = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (mon_done) dones++;
        end
        check("no_extra_done", dones, 0);
        check("no_extra_busy", {31'd0, mon_busy}, 32'd0);

        // Reset during DATA bit 4, then a clean 0x81 transfer.
        pull_en = 1'b1;
        data_r  = 8'h5A;
        start_r = 1'b1;
        @(posedge clk); #1;
        start_r = 1'b0;
        for (int i = 0; i < 300 && mon_bits != 4; i++) begin
            @(posedge clk); #1;
        end
        check("reached_bit4", mon_bits, 4);
        check("busy_before_rst", {31'd0, busy4}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_bus", {scl4, sda4}, 2'b11);
        check("rst_mid_flags", {busy4, done4, ack4}, 3'b000);
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_rst", {scl4, sda4, busy4, done4}, 4'b1100);
        run_xfer(8'h81, 1'b1, 4, 0);
        repeat (3) @(posedge clk);
        #1;

        // CLK_DIV=1, start held high: back-to-back transfers of 0x00.
        sel     = 1'b1;
        pull_en = 1'b1;
        data_r  = 8'h00;
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e.data = 8'h00;
            e.ack  = 1'b1;
            sb_q.push_back(e);
        end
        start_r    = 1'b1;
        dones      = 0;
        cyc        = 0;
        last       = 0;
        after_done = 1'b0;
        while (dones < 3 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            if (after_done) begin
                check("b2b_start_bus", {scl1, sda1, busy1}, 3'b101);
                after_done = 1'b0;
            end
            if (done1) begin
                dones++;
                if (dones == 1) check("b2b_first_done", cyc, 42);
                else            check("b2b_done_spacing", cyc - last, 42);
                last = cyc;
                if (dones == 3) start_r = 1'b0;
                else            after_done = 1'b1;
            end
        end
        check("b2b_done_count", dones, 3);
        repeat (5) @(posedge clk);
        #1;
        check("b2b_idle_after", {scl1, sda1, busy1}, 3'b110);
        check("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
